// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans playfield rows bottom-up and strobes row-advance
// lines to collapse each full row, then reports how many rows were removed.
module line_clear_ctrl #(
  parameter int unsigned COLS = 10,
  parameter int unsigned ROWS = 20,
  localparam int unsigned CW = $clog2(ROWS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   cell_occ,
  output logic [ROWS-1:0]        advance,
  output logic                   busy,
  output logic                   done,
  output logic [CW-1:0]          lines_cleared
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   count_q, count_d;
  logic [ROWS-1:0] advance_d;
  logic            busy_d, done_d;
  logic [CW-1:0]   lines_d;
  logic [COLS-1:0] row_bits;
  logic            row_full, row_empty;

  assign row_bits  = cell_occ[row_q*COLS +: COLS];
  assign row_full  = &row_bits;
  assign row_empty = ~|row_bits;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    count_d   = count_q;
    advance_d = '0;
    busy_d    = busy;
    done_d    = 1'b0;
    lines_d   = lines_cleared;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
          row_d   = RW'(ROWS - 1);
          count_d = '0;
          busy_d  = 1'b1;
        end
      end
      StScan: begin
        if (row_full) begin
          state_d = StShift;
          // Contiguous mask: every row at or above the full row drops by one.
          for (int i = 0; i < int'(ROWS); i++) begin
            advance_d[i] = (RW'(i) <= row_q);
          end
          if (count_q != CW'(ROWS)) count_d = count_q + 1'b1;
        end else if (row_empty || (row_q == '0)) begin
          // An empty row means nothing above it can be occupied.
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          lines_d = count_q;
        end else begin
          row_d = row_q - 1'b1;
        end
      end
      // Rescan the same row next: new contents have dropped into it.
      StShift: state_d = StScan;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      row_q         <= RW'(ROWS - 1);
      count_q       <= '0;
      advance       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      count_q       <= count_d;
      advance       <= advance_d;
      busy          <= busy_d;
      done          <= done_d;
      lines_cleared <= lines_d;
    end
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: emulates the memcell grid, predicts each pass with
// a row-compaction model and checks strobes/results through a scoreboard.
module tb_line_clear_ctrl;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int CW   = $clog2(ROWS + 1);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [ROWS*COLS-1:0] cell_occ = '0;
  logic [ROWS-1:0]      advance;
  logic                 busy, done;
  logic [CW-1:0]        lines_cleared;

  int vec = 0;
  int err = 0;
  int cyc = 0;
  int t0  = 0;
  logic [ROWS-1:0] exp_mask[$];
  int              exp_lines[$];
  int              exp_lat[$];

  line_clear_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .start(start), .cell_occ(cell_occ),
    .advance(advance), .busy(busy), .done(done), .lines_cleared(lines_cleared)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [COLS-1:0] rowv(input logic [ROWS*COLS-1:0] b, input int r);
    return b[r*COLS +: COLS];
  endfunction

  // Rows below the lowest empty row are the only ones reached; each full one
  // has sunk by the number of full rows beneath it when it is cleared.
  task automatic model(input logic [ROWS*COLS-1:0] b, output logic [ROWS*COLS-1:0] fin);
    int e = -1;
    int nb = 0;
    int idx = ROWS - 1;
    int end_row = 0;
    logic [ROWS-1:0] m;
    fin = '0;
    for (int r = ROWS - 1; r >= 0; r--) if (rowv(b, r) == '0) begin e = r; break; end
    for (int r = ROWS - 1; r > e; r--) begin
      if (&rowv(b, r)) begin
        m = '0;
        for (int k = 0; k <= r + nb; k++) m[k] = 1'b1;
        exp_mask.push_back(m);
        nb++;
      end
    end
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!(r > e && (&rowv(b, r)))) begin
        fin[idx*COLS +: COLS] = rowv(b, r);
        idx--;
      end
    end
    for (int r = ROWS - 1; r >= 0; r--) if (rowv(fin, r) == '0) begin end_row = r; break; end
    exp_lines.push_back(nb);
    exp_lat.push_back(ROWS - end_row + 2 * nb + 1);
  endtask

  // Memcell emulation: row i takes row i-1 on its strobe, row 0 loads zero.
  task automatic grid_shift();
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (advance[i]) begin
        if (i == 0) cell_occ[0 +: COLS] = '0;
        else cell_occ[i*COLS +: COLS] = cell_occ[(i-1)*COLS +: COLS];
      end
    end
  endtask

  task automatic run_pass(input logic [ROWS*COLS-1:0] b, input bit poke);
    logic [ROWS*COLS-1:0] fin;
    bit got = 1'b0;
    cell_occ = b;
    model(b, fin);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start = (poke && c == 2);
      if (advance != '0) grid_shift();
      if (done) begin got = 1'b1; break; end
    end
    start = 1'b0;
    if (!got) begin
      vec++; err++;
      $display("FAIL pass_timeout: got no done expected done within 100 cycles");
    end
    chk("final_board", int'(cell_occ), int'(fin));
    if (poke) repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      cyc++;
      if (start && !busy && !done) t0 = cyc;
      if (advance != '0) begin
        if (exp_mask.size() == 0) begin
          vec++; err++;
          $display("FAIL unexpected_advance: got %b expected 0", advance);
        end else chk("advance_mask", int'(advance), int'(exp_mask.pop_front()));
      end
      if (done) begin
        if (exp_lines.size() == 0) begin
          vec++; err++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          chk("lines_cleared", int'(lines_cleared), exp_lines.pop_front());
          chk("pass_latency", cyc - t0, exp_lat.pop_front());
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  initial begin
    logic [ROWS*COLS-1:0] b;
    logic [ROWS*COLS-1:0] fin;
    bit seen;
    #2 reset = 1'b0;
    #2;
    chk("reset_advance", int'(advance), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_lines", int'(lines_cleared), 0);
    @(negedge clk) reset = 1'b1;

    run_pass(16'h0000, 1'b0);                  // empty board
    run_pass(16'hF300, 1'b0);                  // row3 full, row2 partial
    run_pass(16'hFF10, 1'b0);                  // rows 3,2 full, row1=0x1
    run_pass(16'h56F0, 1'b0);                  // only row1 full
    run_pass(16'hFFFF, 1'b0);                  // all full
    run_pass(16'h5FF3, 1'b1);                  // start pulsed while busy
    run_pass(16'h1236, 1'b0);                  // no empty, no full rows

    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < ROWS; r++) begin
        case ($urandom_range(0, 3))
          0: b[r*COLS +: COLS] = '0;
          1: b[r*COLS +: COLS] = '1;
          default: b[r*COLS +: COLS] = COLS'($urandom_range(1, (1 << COLS) - 2));
        endcase
      end
      run_pass(b, 1'b0);
    end

    // Abort mid-pass with reset during the first shift strobe.
    cell_occ = 16'hFFFF;
    model(cell_occ, fin);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (advance != '0) begin seen = 1'b1; break; end
    end
    chk("abort_shift_seen", int'(seen), 1);
    #1 reset = 1'b0;
    #1;
    chk("abort_advance", int'(advance), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_lines", int'(lines_cleared), 0);
    exp_mask.delete();
    exp_lines.delete();
    exp_lat.delete();
    @(negedge clk) reset = 1'b1;
    run_pass(16'hFF00, 1'b0);

    repeat (3) @(negedge clk);
    chk("leftover_masks", exp_mask.size(), 0);
    chk("leftover_results", exp_lines.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
